sha256_nonce_scheduler: RTL and testbench

Sequences a bank of 2**LANE_BITS parallel sha256_transform lanes for the second-block Bitcoin hash. Accepts one work item (midstate, 96-bit block tail, nonce range) and sweeps the nonce range across all lanes, one bank issue per cycle. It collects per-lane hit flags from the bank and returns winning nonces through a valid/ready port. It sits between the host work interface and the hash-lane bank.

---
 rtl/sha256_nonce_scheduler_pkg.sv | 35 +++
 rtl/sha256_nonce_scheduler_if.sv | 39 +++
 rtl/sha256_nonce_scheduler_hit_fifo.sv | 57 +++++
 rtl/sha256_nonce_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_sha256_nonce_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_nonce_scheduler_pkg.sv
// Shared types and constants for the nonce scheduler: FSM states, SHA-256 IV,
// second-block padding words and the hit-FIFO entry layout.
package sha256_miner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DRAIN
  } sched_state_t;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0]  PAD_WORD  = 32'h8000_0000;
  localparam logic [31:0]  LEN_WORD  = 32'h0000_0280;

  // Entries carry a mask sized for the widest supported bank; narrower banks zero-extend.
  localparam int MAX_LANE_BITS = 5;
  localparam int MAX_LANES     = 1 << MAX_LANE_BITS;

  typedef struct packed {
    logic [31:0]          base;
    logic [MAX_LANES-1:0] mask;
  } hit_entry_t;

  function automatic logic [MAX_LANE_BITS-1:0] low_lane(input logic [MAX_LANES-1:0] m);
    logic [MAX_LANE_BITS-1:0] idx;
    idx = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (m[i]) idx = MAX_LANE_BITS'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sha256_nonce_scheduler_if.sv
// Host work port, hash-bank port and result port of the nonce scheduler.
// The scheduler takes the master view; host and bank share the slave view.
interface sha256_nonce_scheduler_if #(
  parameter int LANE_BITS = 3
);
  localparam int LANES = 1 << LANE_BITS;

  logic             work_valid;
  logic             work_ready;
  logic [255:0]     work_midstate;
  logic [95:0]      work_tail;
  logic [31:0]      nonce_start;
  logic [31:0]      nonce_end;
  logic             abort;
  logic             core_issue;
  logic [255:0]     core_state;
  logic [511:0]     core_data;
  logic [LANES-1:0] core_hit;
  logic             found_valid;
  logic             found_ready;
  logic [31:0]      found_nonce;
  logic             busy;
  logic             done;

  modport master (
    input  work_valid, work_midstate, work_tail, nonce_start, nonce_end, abort,
           core_hit, found_ready,
    output work_ready, core_issue, core_state, core_data, found_valid, found_nonce,
           busy, done
  );

  modport slave (
    output work_valid, work_midstate, work_tail, nonce_start, nonce_end, abort,
           core_hit, found_ready,
    input  work_ready, core_issue, core_state, core_data, found_valid, found_nonce,
           busy, done
  );

endinterface

// File: rtl/sha256_nonce_scheduler_hit_fifo.sv
// Synchronous FIFO holding tagged hit entries; simultaneous push and pop are
// both honoured, including a push into a full FIFO that is popping.
module sha256_hit_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] free
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign free    = CNT_W'(DEPTH) - count;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sha256_nonce_scheduler.sv
// Sweeps a nonce range across a bank of parallel SHA-256 lanes, tags returning
// hit masks with their issue base and streams winning nonces out one at a time.
module sha256_nonce_scheduler
  import sha256_miner_pkg::*;
#(
  parameter int LANE_BITS = 3,
  parameter int LATENCY   = 1,
  parameter int HIT_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  sha256_nonce_scheduler_if.master bus
);
  localparam int          LANES       = 1 << LANE_BITS;
  localparam logic [31:0] LANE_MASK   = 32'(LANES - 1);
  localparam logic [31:0] STEP        = 32'(LANES);
  localparam int          FREE_W      = $clog2(HIT_DEPTH + 1);
  localparam int          RESUME_FREE = LATENCY + 2;

  sched_state_t   state;
  logic [31:0]    cur_base, last_base, next_base;
  logic [95:0]    tail_r;
  logic           work_ready_r, busy_r, done_r, issue_r;
  logic [255:0]   core_state_r;
  logic [511:0]   core_data_r;
  logic           abort_go;
  logic           tag_vld, line_empty;
  logic [31:0]    tag_base;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty, room_ok;
  logic [FREE_W-1:0] fifo_free;
  hit_entry_t     push_entry, head;
  logic [MAX_LANES-1:0]     clr_mask, live_mask, low_bit;
  logic [MAX_LANE_BITS-1:0] lane;
  logic           found_hs;

  function automatic logic [511:0] core_block(input logic [95:0] tail, input logic [31:0] base);
    return {tail, base, PAD_WORD, 320'h0, LEN_WORD};
  endfunction

  assign abort_go  = bus.abort && (state != ST_IDLE);
  assign next_base = cur_base + STEP;

  // Issue -> hit boundary: issue valid and base delayed LATENCY cycles
  generate
    if (LATENCY == 0) begin : g_nodelay
      assign tag_vld    = issue_r;
      assign tag_base   = cur_base;
      assign line_empty = 1'b1;
    end else begin : g_delay
      logic [LATENCY-1:0] vld_p;
      logic [31:0]        base_p [LATENCY];

      always_ff @(posedge clk) begin
        if (rst || abort_go) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= issue_r;
          for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        base_p[0] <= cur_base;
        for (int i = 1; i < LATENCY; i++) base_p[i] <= base_p[i-1];
      end

      assign tag_vld    = vld_p[LATENCY-1];
      assign tag_base   = base_p[LATENCY-1];
      assign line_empty = ~|vld_p;
    end
  endgenerate

  // Hit -> FIFO boundary
  assign fifo_push       = tag_vld && (|bus.core_hit) && !fifo_full;
  assign push_entry.base = tag_base;
  assign push_entry.mask = MAX_LANES'(bus.core_hit);
  // Free space is judged after this cycle's push so in-flight issues always fit.
  assign room_ok = (int'(fifo_free) - int'(fifo_push)) >= RESUME_FREE;

  sha256_hit_fifo #(
    .WIDTH ($bits(hit_entry_t)),
    .DEPTH (HIT_DEPTH)
  ) u_hit_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort_go),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  // FIFO head -> result port boundary: one nonce per remaining mask bit
  assign live_mask = head.mask & ~clr_mask;
  assign lane      = low_lane(live_mask);
  assign low_bit   = MAX_LANES'(1) << lane;
  assign found_hs  = !fifo_empty && bus.found_ready;
  assign fifo_pop  = found_hs && ((live_mask & ~low_bit) == '0);

  always_ff @(posedge clk) begin
    if (rst || abort_go || fifo_pop) clr_mask <= '0;
    else if (found_hs)              clr_mask <= clr_mask | low_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      work_ready_r <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      issue_r      <= 1'b0;
      cur_base     <= '0;
      last_base    <= '0;
      core_state_r <= '0;
      core_data_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (abort_go) begin
        state        <= ST_IDLE;
        work_ready_r <= 1'b1;
        busy_r       <= 1'b0;
        issue_r      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.work_valid) begin
              state        <= ST_RUN;
              work_ready_r <= 1'b0;
              busy_r       <= 1'b1;
              issue_r      <= 1'b1;
              cur_base     <= bus.nonce_start & ~LANE_MASK;
              last_base    <= bus.nonce_end & ~LANE_MASK;
              tail_r       <= bus.work_tail;
              core_state_r <= bus.work_midstate;
              core_data_r  <= core_block(bus.work_tail, bus.nonce_start & ~LANE_MASK);
            end
          end
          ST_RUN: begin
            if (cur_base == last_base) begin
              state   <= ST_DRAIN;
              issue_r <= 1'b0;
            end else begin
              cur_base    <= next_base;
              core_data_r <= core_block(tail_r, next_base);
              if (!room_ok) begin
                state   <= ST_PAUSE;
                issue_r <= 1'b0;
              end
            end
          end
          ST_PAUSE: begin
            if (room_ok) begin
              state   <= ST_RUN;
              issue_r <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (line_empty && fifo_empty) begin
              state        <= ST_IDLE;
              work_ready_r <= 1'b1;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.work_ready  = work_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.core_issue  = issue_r;
  assign bus.core_state  = core_state_r;
  assign bus.core_data   = core_data_r;
  assign bus.found_valid = !fifo_empty;
  assign bus.found_nonce = head.base | 32'(lane);

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Scoreboard bench for sha256_nonce_scheduler: a bank model answers issues from a
// hit table, a monitor pops expected issue bases and winning nonces from queues.
module tb_sha256_nonce_scheduler;
  import sha256_miner_pkg::*;

  localparam int LANE_BITS = 3;
  localparam int LATENCY   = 1;
  localparam int HIT_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_nonce_scheduler_if #(.LANE_BITS(LANE_BITS)) bus ();

  sha256_nonce_scheduler #(
    .LANE_BITS (LANE_BITS),
    .LATENCY   (LATENCY),
    .HIT_DEPTH (HIT_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_issue [$];
  logic [31:0] exp_found [$];
  logic [7:0]  hit_map [logic [31:0]];
  int issue_cnt = 0;
  int done_cnt  = 0;
  int fv_cnt    = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_nonce = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Bank model: the hit for an issue appears LATENCY (=1) cycles later.
  always @(posedge clk) begin : bank
    logic        iss;
    logic [31:0] b;
    iss = bus.core_issue;
    b   = bus.core_data[415:384];
    #1;
    bus.core_hit = (iss && hit_map.exists(b)) ? hit_map[b] : 8'h00;
  end

  // Monitor: compares against the scoreboard queues whenever the DUT presents output.
  always @(negedge clk) begin
    if (bus.core_issue) begin
      issue_cnt++;
      if (exp_issue.size() == 0) fail_now("issue_unexpected", $sformatf("base %0h with none expected", bus.core_data[415:384]));
      else check("issue_base", bus.core_data[415:384], exp_issue.pop_front());
    end
    if (bus.done) done_cnt++;
    if (bus.found_valid) begin
      fv_cnt++;
      if (prev_stall) check("found_stable", bus.found_nonce, prev_nonce);
      if (bus.found_ready) begin
        if (exp_found.size() == 0) fail_now("found_unexpected", $sformatf("nonce %0h with none expected", bus.found_nonce));
        else check("found_nonce", bus.found_nonce, exp_found.pop_front());
      end
    end
    prev_stall = bus.found_valid && !bus.found_ready;
    prev_nonce = bus.found_nonce;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_work_ready"},  bus.work_ready, 1);
    check({tag, "_core_issue"},  bus.core_issue, 0);
    check({tag, "_found_valid"}, bus.found_valid, 0);
    check({tag, "_busy"},        bus.busy, 0);
    check({tag, "_done"},        bus.done, 0);
    check({tag, "_core_state"},  bus.core_state, 0);
    check({tag, "_core_data"},   bus.core_data, 0);
  endtask

  // Returns at the negedge of the first cycle after acceptance.
  task automatic send_work(input logic [31:0] s, input logic [31:0] e);
    int guard = 0;
    logic [95:0]  tail;
    logic [255:0] mid;
    while (!bus.work_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!bus.work_ready) fail_now("work_ready_timeout", "scheduler never returned to idle");
    tail = {s, e, 32'h1d00ffff};
    mid  = SHA256_IV ^ {8{s}};
    bus.work_midstate = mid;
    bus.work_tail     = tail;
    bus.nonce_start   = s;
    bus.nonce_end     = e;
    bus.work_valid    = 1'b1;
    tick();
    bus.work_valid    = 1'b0;
    @(negedge clk);
    check("first_issue", bus.core_issue, 1);
    check("busy_run",    bus.busy, 1);
    check("core_state",  bus.core_state, mid);
    check("core_tail",   bus.core_data[511:416], tail);
    check("core_pad",    bus.core_data[383:352], 32'h8000_0000);
    check("core_len",    bus.core_data[351:0], 352'h280);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    if (done_cnt == d0) fail_now("done_timeout", "no done pulse within budget");
    repeat (4) tick();
    check("done_once",       done_cnt - d0, 1);
    check("idle_after_done", bus.busy, 0);
    check("issue_q_empty",   exp_issue.size(), 0);
    check("found_q_empty",   exp_found.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0;
    int fv0;
    int d0;
    bus.work_valid    = 1'b0;
    bus.work_midstate = '0;
    bus.work_tail     = '0;
    bus.nonce_start   = '0;
    bus.nonce_end     = '0;
    bus.abort         = 1'b0;
    bus.found_ready   = 1'b1;
    bus.core_hit      = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    tick();
    rst = 1'b0;
    tick();

    // No hits: four bases, one done, nothing found.
    i0 = issue_cnt; fv0 = fv_cnt;
    exp_issue = '{32'h0, 32'h8, 32'h10, 32'h18};
    send_work(32'h0, 32'h1f);
    wait_done(40);
    check("t1_issues",   issue_cnt - i0, 4);
    check("t1_no_found", fv_cnt - fv0, 0);

    // Mask 8'b1000_0100 on base 0x10; result held stable while stalled.
    hit_map[32'h10] = 8'h84;
    exp_issue = '{32'h0, 32'h8, 32'h10, 32'h18};
    exp_found = '{32'h12, 32'h17};
    bus.found_ready = 1'b0;
    send_work(32'h0, 32'h1f);
    repeat (3) @(negedge clk);
    check("t2_not_yet_valid", bus.found_valid, 0);
    @(negedge clk);
    check("t2_first_valid", bus.found_valid, 1);
    repeat (3) begin
      @(negedge clk);
      check("t2_hold_valid", bus.found_valid, 1);
      check("t2_hold_nonce", bus.found_nonce, 32'h12);
    end
    tick();
    bus.found_ready = 1'b1;
    wait_done(40);
    hit_map.delete();

    // Sweep wrapping through zero.
    i0 = issue_cnt;
    exp_issue = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0};
    send_work(32'hFFFF_FFF0, 32'h0000_0007);
    wait_done(40);
    check("t3_issues", issue_cnt - i0, 3);

    // A hit on every issue with results stalled: must pause, then emit all in order.
    i0 = issue_cnt;
    for (int i = 0; i < 8; i++) begin
      hit_map[32'(8 * i)] = 8'(1 << i);
      exp_issue.push_back(32'(8 * i));
      exp_found.push_back(32'(9 * i));
    end
    bus.found_ready = 1'b0;
    send_work(32'h0, 32'h3f);
    repeat (10) tick();
    check("t4_paused_issues", issue_cnt - i0, 3);
    check("t4_busy",          bus.busy, 1);
    check("t4_stalled_valid", bus.found_valid, 1);
    bus.found_ready = 1'b1;
    wait_done(100);
    check("t4_issues", issue_cnt - i0, 8);
    hit_map.delete();

    // Abort two cycles in, with the hit for base 8 still in flight.
    hit_map[32'h8] = 8'h01;
    exp_issue = '{32'h0, 32'h8};
    d0 = done_cnt; fv0 = fv_cnt;
    send_work(32'h0, 32'h3ff);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("t5_busy",       bus.busy, 0);
    check("t5_work_ready", bus.work_ready, 1);
    check("t5_core_issue", bus.core_issue, 0);
    check("t5_found",      bus.found_valid, 0);
    repeat (6) tick();
    check("t5_no_done",  done_cnt - d0, 0);
    check("t5_no_found", fv_cnt - fv0, 0);
    check("t5_issue_q",  exp_issue.size(), 0);
    hit_map.delete();

    // New work after abort: single base gives exactly one issue.
    i0 = issue_cnt;
    exp_issue = '{32'h100};
    send_work(32'h100, 32'h107);
    wait_done(20);
    check("t5_single_issue", issue_cnt - i0, 1);

    // Reset in the middle of a sweep.
    i0 = issue_cnt;
    exp_issue = '{32'h0, 32'h8, 32'h10};
    send_work(32'h0, 32'h3ff);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset("midrun_reset");
    check("t6_issues", issue_cnt - i0, 3);
    repeat (3) tick();
    check("t6_issue_q", exp_issue.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
